// File: rtl/mealy_seq_detect.sv
// rtl/mealy_seq_detect.sv - parametrised Mealy serial-pattern detector with saturating match counter
//
// Detects a runtime-loadable PAT_WIDTH-bit pattern on a gated serial input.
// The first bit received is compared against pattern bit PAT_WIDTH-1.
// Matching is overlapping or non-overlapping, selected by overlap_en.
//
// Ports:
//   clk          in   rising-edge clock
//   n_rst        in   asynchronous active-low reset
//   i            in   serial data bit
//   in_valid     in   i is accepted this cycle when high (unless loading)
//   load_pattern in   capture pattern_in, flush history; beats in_valid
//   pattern_in   in   [PAT_WIDTH-1:0] new pattern
//   overlap_en   in   1: overlapping matches, 0: history restarts after a match
//   clear_count  in   synchronous clear of match_count, beats a match
//   o            out  Mealy match flag, combinational from i
//   match_count  out  [CNT_WIDTH-1:0] saturating match count
//   count_sat    out  match_count is all ones

module mealy_seq_detect #(
    parameter int                   PAT_WIDTH     = 4,
    parameter int                   CNT_WIDTH     = 8,
    parameter logic [PAT_WIDTH-1:0] RESET_PATTERN = 4'b1101
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i,
    input  logic                 in_valid,
    input  logic                 load_pattern,
    input  logic [PAT_WIDTH-1:0] pattern_in,
    input  logic                 overlap_en,
    input  logic                 clear_count,
    output logic                 o,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 count_sat
);

    // fill counts 0..PAT_WIDTH-1, so $clog2(PAT_WIDTH) bits always suffice
    localparam int FILL_W = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_WIDTH - 1);

    logic [PAT_WIDTH-1:0] pattern_q, pattern_d;
    logic [PAT_WIDTH-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic                 accept;
    logic [PAT_WIDTH-1:0] window;
    logic                 match;
    logic                 sat;

    assign accept = in_valid & ~load_pattern;
    // Oldest held bit lands in the MSB, matching pattern bit order
    assign window = {hist_q, i};
    assign match  = accept & (fill_q == FILL_MAX) & (window == pattern_q);
    assign sat    = &count_q;

    always_comb begin
        pattern_d = pattern_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;

        if (load_pattern) begin
            pattern_d = pattern_in;
            hist_d    = '0;
            fill_d    = '0;
        end else if (accept) begin
            if (match && !overlap_en) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                // Dropping window's MSB shifts the new bit in at hist[0];
                // this form stays legal for PAT_WIDTH == 2
                hist_d = window[PAT_WIDTH-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end

        if (clear_count) begin
            count_d = '0;
        end else if (match && !sat) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pattern_q <= RESET_PATTERN;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
        end
    end

    assign o           = match;
    assign match_count = count_q;
    assign count_sat   = sat;

endmodule

// File: tb/tb_mealy_seq_detect.sv
// tb/tb_mealy_seq_detect.sv - self-checking bench for mealy_seq_detect
module tb_mealy_seq_detect;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       i = 1'b0;
    logic       in_valid = 1'b0;
    logic       load_pattern = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       overlap_en = 1'b1;
    logic       clear_count = 1'b0;

    logic       o_a, sat_a, o_s, sat_s;
    logic [7:0] cnt_a;
    logic [2:0] cnt_s;

    int checks = 0;
    int fails  = 0;

    // Reference model: list of accepted bits since the last restart, oldest first
    bit mq[$];
    int pat;
    int ca, cs;
    bit eo;

    always #5 clk = ~clk;

    mealy_seq_detect #(.PAT_WIDTH(4), .CNT_WIDTH(8), .RESET_PATTERN(4'b1101)) dut (
        .clk(clk), .n_rst(n_rst), .i(i), .in_valid(in_valid),
        .load_pattern(load_pattern), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .clear_count(clear_count),
        .o(o_a), .match_count(cnt_a), .count_sat(sat_a)
    );

    mealy_seq_detect #(.PAT_WIDTH(4), .CNT_WIDTH(3), .RESET_PATTERN(4'b1101)) dut_s (
        .clk(clk), .n_rst(n_rst), .i(i), .in_valid(in_valid),
        .load_pattern(load_pattern), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .clear_count(clear_count),
        .o(o_s), .match_count(cnt_s), .count_sat(sat_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_o(input bit ib, input bit acc);
        int v;
        if (!acc || mq.size() < P - 1) return 1'b0;
        v = 0;
        foreach (mq[k]) v = (v << 1) | int'(mq[k]);
        v = (v << 1) | int'(ib);
        return v == pat;
    endfunction

    task automatic model_reset();
        mq.delete();
        pat = 4'b1101;
        ca  = 0;
        cs  = 0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(ca));
        chk({tag, ".sat_a"}, 32'(sat_a), 32'(ca == 255));
        chk({tag, ".cnt_s"}, 32'(cnt_s), 32'(cs));
        chk({tag, ".sat_s"}, 32'(sat_s), 32'(cs == 7));
    endtask

    // One clock cycle: drive at negedge, check Mealy output mid-cycle,
    // advance the model on the edge, then check the registered counters.
    task automatic step(input bit ib, input bit v, input bit lp, input logic [3:0] pin,
                        input bit ov, input bit clr, input string tag);
        bit acc;
        @(negedge clk);
        i = ib; in_valid = v; load_pattern = lp; pattern_in = pin;
        overlap_en = ov; clear_count = clr;
        acc = v && !lp;
        eo  = model_o(ib, acc);
        #1;
        chk({tag, ".o_a"}, 32'(o_a), 32'(eo));
        chk({tag, ".o_s"}, 32'(o_s), 32'(eo));
        @(posedge clk);
        if (lp) begin
            pat = int'(pin);
            mq.delete();
        end else if (acc) begin
            if (eo && !ov) begin
                mq.delete();
            end else begin
                mq.push_back(ib);
                while (mq.size() > P - 1) void'(mq.pop_front());
            end
        end
        if (clr) begin
            ca = 0; cs = 0;
        end else if (eo) begin
            if (ca < 255) ca++;
            if (cs < 7) cs++;
        end
        #1;
        chk_counts(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i = 0; in_valid = 0; load_pattern = 0; clear_count = 0; overlap_en = 1;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("rst.o", 32'(o_a), 32'd0);
        chk_counts("rst");
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input bit ov, input string tag);
        for (int k = n - 1; k >= 0; k--) step(bits[k], 1, 0, 4'h0, ov, 0, tag);
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // Overlapping 1101101: matches on bits 4 and 7
        feed(16'b1101101, 7, 1, "t1");
        chk("t1.count", 32'(cnt_a), 32'd2);
        chk("t1.sat", 32'(sat_a), 32'd0);

        // Non-overlapping: only bit 4 matches
        do_reset();
        feed(16'b1101101, 7, 0, "t2");
        chk("t2.count", 32'(cnt_a), 32'd1);

        // Valid gating: gap of in_valid=0 with i=1 is ignored
        do_reset();
        feed(16'b110, 3, 1, "t3");
        for (int k = 0; k < 3; k++) step(1, 0, 0, 4'h0, 1, 0, "t3.gap");
        step(1, 1, 0, 4'h0, 1, 0, "t3.last");
        chk("t3.count", 32'(cnt_a), 32'd1);

        // Pattern reload mid-stream
        do_reset();
        feed(16'b11, 2, 1, "t4.pre");
        step(0, 1, 1, 4'b0000, 1, 0, "t4.load");
        feed(16'b00000, 5, 1, "t4");
        chk("t4.count", 32'(cnt_a), 32'd2);

        // Saturation of the 3-bit counter, then clear in a match cycle
        do_reset();
        feed(16'b1101, 4, 1, "t5.a");
        for (int k = 0; k < 8; k++) feed(16'b101, 3, 1, "t5.b");
        chk("t5.cnt_s", 32'(cnt_s), 32'd7);
        chk("t5.sat_s", 32'(sat_s), 32'd1);
        chk("t5.cnt_a", 32'(cnt_a), 32'd9);
        feed(16'b10, 2, 1, "t5.c");
        step(1, 1, 0, 4'h0, 1, 1, "t5.clr");
        chk("t5.cleared", 32'(cnt_s), 32'd0);

        // Asynchronous reset in the middle of a cycle
        do_reset();
        step(0, 0, 1, 4'b0110, 1, 0, "t6.load");
        feed(16'b011, 3, 1, "t6.pre");
        @(negedge clk);
        i = 0; in_valid = 1;
        #1;
        chk("t6.o_before", 32'(o_a), 32'd1);
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        chk("t6.o_async", 32'(o_a), 32'd0);
        chk_counts("t6.async");
        @(negedge clk);
        in_valid = 0;
        n_rst = 1'b1;
        feed(16'b1101, 4, 1, "t6.post");
        chk("t6.count", 32'(cnt_a), 32'd1);

        // Randomised traffic against the reference model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit          rb, rv, rl, ro, rc;
            logic [3:0]  rp;
            rb = 1'($urandom);
            rv = ($urandom_range(0, 9) < 8);
            rl = ($urandom_range(0, 49) == 0);
            rp = ($urandom_range(0, 1) == 0) ? 4'b1101 : 4'($urandom);
            ro = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 99) == 0);
            step(rb, rv, rl, rp, ro, rc, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
